vga_bus_arbiter: RTL and testbench

Shares the card's 16-bit ISA-style VGA bus (DG, SA0/SA12, BALE, IOR/IOW/MEMR/MEMW, WAIT) between two requesters: port 0 is the Amiga Zorro II slave path, port 1 is an on-CPLD register sequencer (mode init, monitor switch, palette loads). It grants one bus cycle at a time and generates setup, command and hold phases with programmable widths. It honours WAIT on memory cycles, with a timeout. It returns read data and a one-cycle acknowledge to the granted port.

---
 rtl/vga_bus_pkg.sv | 31 +++
 rtl/vga_bus_timer.sv | 41 ++++
 rtl/vga_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_vga_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_bus_pkg
// Brief   : Shared types and constants for the VGA bus arbiter.
// Revision: 1.0
// ============================================================================
package vga_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_CMD   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    typedef struct packed {
        logic io;
        logic rw;
    } cycle_kind_t;

    localparam logic [15:0] DG_IDLE = 16'h0001;
    localparam int          CNT_W   = 8;

    // Phase counters are loaded with N-1 so that zero marks the last cycle.
    function automatic logic [CNT_W-1:0] phase_load(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : vga_bus_timer
// Brief   : 8-bit loadable down-counter with zero flag, shared by all phases.
// Revision: 1.0
// ============================================================================
module vga_bus_timer
    import vga_bus_pkg::*;
(
    input  logic             mclk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/vga_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_bus_arbiter
// Brief   : Two-port arbiter and cycle generator for the 16-bit VGA bus.
// Revision: 1.0
// ============================================================================
module vga_bus_arbiter
    import vga_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int CMD_CYCLES   = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        mclk_i,
    input  logic        reset_i,
    input  logic        req0_i,
    input  logic        io0_i,
    input  logic        rw0_i,
    input  logic        sa0_0_i,
    input  logic        sa12_0_i,
    input  logic [15:0] wdata0_i,
    output logic        ack0_o,
    output logic        err0_o,
    input  logic        req1_i,
    input  logic        io1_i,
    input  logic        rw1_i,
    input  logic        sa0_1_i,
    input  logic        sa12_1_i,
    input  logic [15:0] wdata1_i,
    output logic        ack1_o,
    output logic        err1_o,
    output logic [15:0] rdata_o,
    input  logic        wait_n_i,
    input  logic [15:0] dg_in_i,
    output logic        bale_o,
    output logic        ior_o,
    output logic        iow_o,
    output logic        memr_o,
    output logic        memw_o,
    output logic        sa0_o,
    output logic        sa12_o,
    output logic [15:0] dg_out_o,
    output logic        dg_oe_o
);

    if ((SETUP_CYCLES < 1) || (SETUP_CYCLES > 255) ||
        (CMD_CYCLES   < 1) || (CMD_CYCLES   > 255) ||
        (HOLD_CYCLES  < 1) || (HOLD_CYCLES  > 255) ||
        (TIMEOUT      < 0) || (TIMEOUT      > 255)) begin : g_bad_params
        $error("vga_bus_arbiter: phase widths must be 1..255, TIMEOUT 0..255");
    end

    localparam logic [CNT_W-1:0] c_SETUP_LD   = phase_load(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] c_CMD_LD     = phase_load(CMD_CYCLES);
    localparam logic [CNT_W-1:0] c_HOLD_LD    = phase_load(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LD = (TIMEOUT > 0) ? phase_load(TIMEOUT) : '0;

    state_e      state_q,   state_d;
    logic        port_q,    port_d;
    cycle_kind_t kind_q,    kind_d;
    logic        sa0_l_q,   sa0_l_d;
    logic        sa12_l_q,  sa12_l_d;
    logic [15:0] wdata_q,   wdata_d;
    logic        waiting_q, waiting_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  streak_q,  streak_d;
    logic [15:0] rdata_q,   rdata_d;

    logic        bale_q, ior_q, iow_q, memr_q, memw_q, sa0_q, sa12_q, dg_oe_q;
    logic        bale_d, ior_d, iow_d, memr_d, memw_d, sa0_d, sa12_d, dg_oe_d;
    logic [15:0] dg_out_q, dg_out_d;
    logic        ack0_q, ack1_q, err0_q, err1_q;
    logic        ack0_d, ack1_d, err0_d, err1_d;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_zero;
    logic             w_leave;
    logic             w_leave_to;
    logic             w_pick1;

    vga_bus_timer u_timer (
        .mclk_i     (mclk_i),
        .reset_i    (reset_i),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .zero_o     (w_tmr_zero)
    );

    // Next-state logic, latching of the granted request and phase timing.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        kind_d     = kind_q;
        sa0_l_d    = sa0_l_q;
        sa12_l_d   = sa12_l_q;
        wdata_d    = wdata_q;
        waiting_d  = waiting_q;
        timeout_d  = timeout_q;
        streak_d   = streak_q;
        rdata_d    = rdata_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        w_leave    = 1'b0;
        w_leave_to = 1'b0;
        w_pick1    = req1_i && (!req0_i || (streak_q == 2'd2));

        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    state_d    = ST_SETUP;
                    port_d     = w_pick1;
                    kind_d.io  = w_pick1 ? io1_i    : io0_i;
                    kind_d.rw  = w_pick1 ? rw1_i    : rw0_i;
                    sa0_l_d    = w_pick1 ? sa0_1_i  : sa0_0_i;
                    sa12_l_d   = w_pick1 ? sa12_1_i : sa12_0_i;
                    wdata_d    = w_pick1 ? wdata1_i : wdata0_i;
                    waiting_d  = 1'b0;
                    timeout_d  = 1'b0;
                    streak_d   = w_pick1 ? 2'd0 :
                                 ((streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1);
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (w_tmr_zero) begin
                    state_d    = ST_CMD;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_CMD_LD;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_CMD: begin
                // Ready always beats timeout when both land on the same edge.
                if (waiting_q) begin
                    if (wait_n_i) begin
                        w_leave = 1'b1;
                    end else if (w_tmr_zero) begin
                        w_leave    = 1'b1;
                        w_leave_to = 1'b1;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end else if (!w_tmr_zero) begin
                    w_tmr_en = 1'b1;
                end else if (kind_q.io || wait_n_i) begin
                    w_leave = 1'b1;
                end else if (TIMEOUT == 0) begin
                    w_leave    = 1'b1;
                    w_leave_to = 1'b1;
                end else begin
                    waiting_d  = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_TIMEOUT_LD;
                end
                if (w_leave) begin
                    state_d    = ST_HOLD;
                    timeout_d  = w_leave_to;
                    rdata_d    = w_leave_to ? 16'hFFFF : dg_in_i;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    state_d = ST_ACK;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus controls are registered from the next state so they change cleanly on edges.
    always_comb begin
        logic busy;
        logic strobe;
        logic wr;
        busy     = (state_d == ST_SETUP) || (state_d == ST_CMD) || (state_d == ST_HOLD);
        strobe   = (state_d == ST_CMD);
        wr       = busy && !kind_d.rw;
        bale_d   = !busy;
        sa0_d    = busy ? sa0_l_d  : 1'b1;
        sa12_d   = busy ? sa12_l_d : 1'b1;
        dg_oe_d  = wr;
        dg_out_d = wr ? wdata_d : DG_IDLE;
        ior_d    = !(strobe &&  kind_d.io &&  kind_d.rw);
        iow_d    = !(strobe &&  kind_d.io && !kind_d.rw);
        memr_d   = !(strobe && !kind_d.io &&  kind_d.rw);
        memw_d   = !(strobe && !kind_d.io && !kind_d.rw);
        ack0_d   = (state_d == ST_ACK) && !port_d;
        ack1_d   = (state_d == ST_ACK) &&  port_d;
        err0_d   = ack0_d && timeout_d;
        err1_d   = ack1_d && timeout_d;
    end

    always_ff @(posedge mclk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            port_q    <= 1'b0;
            kind_q    <= '0;
            sa0_l_q   <= 1'b1;
            sa12_l_q  <= 1'b1;
            wdata_q   <= '0;
            waiting_q <= 1'b0;
            timeout_q <= 1'b0;
            streak_q  <= 2'd0;
            rdata_q   <= '0;
            bale_q    <= 1'b1;
            ior_q     <= 1'b1;
            iow_q     <= 1'b1;
            memr_q    <= 1'b1;
            memw_q    <= 1'b1;
            sa0_q     <= 1'b1;
            sa12_q    <= 1'b1;
            dg_out_q  <= DG_IDLE;
            dg_oe_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            kind_q    <= kind_d;
            sa0_l_q   <= sa0_l_d;
            sa12_l_q  <= sa12_l_d;
            wdata_q   <= wdata_d;
            waiting_q <= waiting_d;
            timeout_q <= timeout_d;
            streak_q  <= streak_d;
            rdata_q   <= rdata_d;
            bale_q    <= bale_d;
            ior_q     <= ior_d;
            iow_q     <= iow_d;
            memr_q    <= memr_d;
            memw_q    <= memw_d;
            sa0_q     <= sa0_d;
            sa12_q    <= sa12_d;
            dg_out_q  <= dg_out_d;
            dg_oe_q   <= dg_oe_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign bale_o   = bale_q;
    assign ior_o    = ior_q;
    assign iow_o    = iow_q;
    assign memr_o   = memr_q;
    assign memw_o   = memw_q;
    assign sa0_o    = sa0_q;
    assign sa12_o   = sa12_q;
    assign dg_out_o = dg_out_q;
    assign dg_oe_o  = dg_oe_q;
    assign ack0_o   = ack0_q;
    assign ack1_o   = ack1_q;
    assign err0_o   = err0_q;
    assign err1_o   = err1_q;
    assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_bus_arbiter
// Brief   : Self-checking bench for vga_bus_arbiter (directed table + random).
// Revision: 1.0
// ============================================================================
module tb_vga_bus_arbiter;

    localparam int c_S = 2;
    localparam int c_C = 4;
    localparam int c_H = 2;
    localparam int c_T = 10;

    logic        mclk = 1'b0;
    logic        reset;
    logic        req0, io0, rw0, sa0_0, sa12_0;
    logic        req1, io1, rw1, sa0_1, sa12_1;
    logic [15:0] wdata0, wdata1, dg_in;
    logic        wait_n;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata, dg_out;
    logic        bale, ior, iow, memr, memw, sa0, sa12, dg_oe;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 mclk = ~mclk;

    vga_bus_arbiter #(
        .SETUP_CYCLES (c_S),
        .CMD_CYCLES   (c_C),
        .HOLD_CYCLES  (c_H),
        .TIMEOUT      (c_T)
    ) dut (
        .mclk_i   (mclk),
        .reset_i  (reset),
        .req0_i   (req0),
        .io0_i    (io0),
        .rw0_i    (rw0),
        .sa0_0_i  (sa0_0),
        .sa12_0_i (sa12_0),
        .wdata0_i (wdata0),
        .ack0_o   (ack0),
        .err0_o   (err0),
        .req1_i   (req1),
        .io1_i    (io1),
        .rw1_i    (rw1),
        .sa0_1_i  (sa0_1),
        .sa12_1_i (sa12_1),
        .wdata1_i (wdata1),
        .ack1_o   (ack1),
        .err1_o   (err1),
        .rdata_o  (rdata),
        .wait_n_i (wait_n),
        .dg_in_i  (dg_in),
        .bale_o   (bale),
        .ior_o    (ior),
        .iow_o    (iow),
        .memr_o   (memr),
        .memw_o   (memw),
        .sa0_o    (sa0),
        .sa12_o   (sa12),
        .dg_out_o (dg_out),
        .dg_oe_o  (dg_oe)
    );

    typedef struct {
        int          port;
        bit          io;
        bit          rw;
        bit          s0;
        bit          s12;
        logic [15:0] wd;
        logic [15:0] dg;
        int          wext;
        int          ack_edge;
        bit          err;
        logic [15:0] rd;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " bale"},   {15'd0, bale},   16'd1);
        chk({tag, " ior"},    {15'd0, ior},    16'd1);
        chk({tag, " iow"},    {15'd0, iow},    16'd1);
        chk({tag, " memr"},   {15'd0, memr},   16'd1);
        chk({tag, " memw"},   {15'd0, memw},   16'd1);
        chk({tag, " sa0"},    {15'd0, sa0},    16'd1);
        chk({tag, " sa12"},   {15'd0, sa12},   16'd1);
        chk({tag, " dg_oe"},  {15'd0, dg_oe},  16'd0);
        chk({tag, " dg_out"}, dg_out,          16'h0001);
        chk({tag, " acks"},   {14'd0, ack1, ack0}, 16'd0);
        chk({tag, " errs"},   {14'd0, err1, err0}, 16'd0);
    endtask

    task automatic drive_port(input int port, input bit rq, input bit io, input bit rw,
                              input bit s0, input bit s12, input logic [15:0] wd);
        if (port == 0) begin
            req0 = rq; io0 = io; rw0 = rw; sa0_0 = s0; sa12_0 = s12; wdata0 = wd;
        end else begin
            req1 = rq; io1 = io; rw1 = rw; sa0_1 = s0; sa12_1 = s12; wdata1 = wd;
        end
    endtask

    // One access from request to the idle cycle after ack; outputs checked every edge.
    // wait_n is low for edges 0 .. S+C+wext-1 and high afterwards.
    task automatic run_txn(input int port, input bit io, input bit rw, input bit s0,
                           input bit s12, input logic [15:0] wd, input logic [15:0] dg,
                           input int wext, input int ack_edge, input bit err,
                           input logic [15:0] exp_rd, input bit wiggle);
        int  rise;
        bit  busy, low;
        rise  = ack_edge - c_H;
        drive_port(port, 1'b1, io, rw, s0, s12, wd);
        dg_in  = dg;
        wait_n = (0 < c_S + c_C + wext) ? 1'b0 : 1'b1;
        for (int e = 0; e <= ack_edge; e++) begin
            @(posedge mclk);
            #1;
            busy = (e < ack_edge);
            low  = (e >= c_S) && (e < rise);
            chk($sformatf("bale e%0d", e),   {15'd0, bale}, {15'd0, !busy});
            chk($sformatf("ior e%0d", e),    {15'd0, ior},  {15'd0, !(low &&  io &&  rw)});
            chk($sformatf("iow e%0d", e),    {15'd0, iow},  {15'd0, !(low &&  io && !rw)});
            chk($sformatf("memr e%0d", e),   {15'd0, memr}, {15'd0, !(low && !io &&  rw)});
            chk($sformatf("memw e%0d", e),   {15'd0, memw}, {15'd0, !(low && !io && !rw)});
            chk($sformatf("sa0 e%0d", e),    {15'd0, sa0},  {15'd0, busy ? s0  : 1'b1});
            chk($sformatf("sa12 e%0d", e),   {15'd0, sa12}, {15'd0, busy ? s12 : 1'b1});
            chk($sformatf("dg_oe e%0d", e),  {15'd0, dg_oe}, {15'd0, busy && !rw});
            chk($sformatf("dg_out e%0d", e), dg_out, (busy && !rw) ? wd : 16'h0001);
            chk($sformatf("ack0 e%0d", e),   {15'd0, ack0}, {15'd0, (e == ack_edge) && (port == 0)});
            chk($sformatf("ack1 e%0d", e),   {15'd0, ack1}, {15'd0, (e == ack_edge) && (port == 1)});
            chk($sformatf("err0 e%0d", e),   {15'd0, err0}, {15'd0, (e == ack_edge) && (port == 0) && err});
            chk($sformatf("err1 e%0d", e),   {15'd0, err1}, {15'd0, (e == ack_edge) && (port == 1) && err});
            if ((e == ack_edge) && rw)
                chk($sformatf("rdata e%0d", e), rdata, exp_rd);
            wait_n = (e + 1 < c_S + c_C + wext) ? 1'b0 : 1'b1;
            if (e == ack_edge) begin
                drive_port(port, 1'b0, io, rw, s0, s12, wd);
            end else if (wiggle) begin
                drive_port(port, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
        wait_n = 1'b1;
        @(posedge mclk);
        #1;
        check_idle_outputs("post_ack");
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge mclk);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   wp, ack_e, grants, run0, exp_w, last_edge, cyc;
        bit   err_e;

        vecs[0] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 0,    8,  1'b0, 16'h0000};
        vecs[1] = '{1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 3,    11, 1'b0, 16'hBEEF};
        vecs[2] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h5555, 1000, 18, 1'b1, 16'hFFFF};
        vecs[3] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1000, 8,  1'b0, 16'hA5A5};
        vecs[4] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0F0F, 16'h0000, 0,    8,  1'b0, 16'h0000};
        vecs[5] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hC3C3, 16'h0000, 0,    8,  1'b0, 16'h0000};
        vecs[6] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1357, 10,   18, 1'b0, 16'h1357};
        vecs[7] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2468, 9,    17, 1'b0, 16'h2468};

        reset = 1'b1;
        req0 = 0; io0 = 0; rw0 = 0; sa0_0 = 0; sa12_0 = 0; wdata0 = '0;
        req1 = 0; io1 = 0; rw1 = 0; sa0_1 = 0; sa12_1 = 0; wdata1 = '0;
        wait_n = 1'b1;
        dg_in  = '0;
        repeat (2) @(posedge mclk);
        #1;
        check_idle_outputs("reset");
        chk("reset rdata", rdata, 16'h0000);
        reset = 1'b0;
        @(posedge mclk);
        #1;

        foreach (vecs[i]) begin
            v = vecs[i];
            run_txn(v.port, v.io, v.rw, v.s0, v.s12, v.wd, v.dg, v.wext,
                    v.ack_edge, v.err, v.rd, 1'b0);
        end

        // Both ports requesting continuously: after two port-0 grants port 1 gets one.
        pulse_reset();
        drive_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111);
        drive_port(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222);
        grants = 0; run0 = 0; last_edge = -1; cyc = 0;
        while ((grants < 6) && (cyc < 120)) begin
            @(posedge mclk);
            #1;
            if (ack0 || ack1) begin
                exp_w = (run0 >= 2) ? 1 : 0;
                chk($sformatf("arb grant%0d port", grants), {15'd0, ack1}, exp_w[15:0]);
                chk($sformatf("arb grant%0d single", grants), {15'd0, ack0 & ack1}, 16'd0);
                if (last_edge >= 0)
                    chk($sformatf("arb grant%0d spacing", grants), 16'(cyc - last_edge),
                        16'(c_S + c_C + c_H + 2));
                run0      = (exp_w == 0) ? run0 + 1 : 0;
                last_edge = cyc;
                grants++;
            end
            cyc++;
        end
        if (grants < 6) begin
            n_chk++;
            n_fail++;
            $display("FAIL arb timeout: got %0d grants required 6", grants);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (12) @(posedge mclk);
        #1;
        check_idle_outputs("arb drained");

        // Reset in the middle of a write: no ack, bus released, next access normal.
        drive_port(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h7777);
        for (int e = 0; e < 3; e++) begin
            @(posedge mclk);
            #1;
            chk($sformatf("rst_mid bale e%0d", e), {15'd0, bale}, 16'd0);
        end
        reset = 1'b1;
        @(posedge mclk);
        #1;
        check_idle_outputs("rst_mid e3");
        reset = 1'b0;
        req0  = 1'b0;
        @(posedge mclk);
        #1;
        check_idle_outputs("rst_mid e4");
        for (int e = 5; e < 16; e++) begin
            @(posedge mclk);
            #1;
            chk($sformatf("rst_mid noack e%0d", e), {14'd0, ack1, ack0}, 16'd0);
        end
        run_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 0, 8, 1'b0, 16'h0000, 1'b0);

        // Random accesses with live inputs disturbed mid-cycle.
        for (int n = 0; n < 40; n++) begin
            v.port = int'($urandom_range(0, 1));
            v.io   = 1'($urandom_range(0, 1));
            v.rw   = 1'($urandom_range(0, 1));
            v.s0   = 1'($urandom_range(0, 1));
            v.s12  = 1'($urandom_range(0, 1));
            v.wd   = 16'($urandom);
            v.dg   = 16'($urandom);
            v.wext = int'($urandom_range(0, 13));
            wp     = v.io ? 0 : ((v.wext > c_T) ? c_T : v.wext);
            err_e  = !v.io && (v.wext > c_T);
            ack_e  = c_S + c_C + wp + c_H;
            run_txn(v.port, v.io, v.rw, v.s0, v.s12, v.wd, v.dg, v.wext, ack_e, err_e,
                    err_e ? 16'hFFFF : v.dg, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
